// File: rtl/board_io_conditioner.sv
// board_io_conditioner
//   Board-I/O front end between raw user pins and SoC pad signals.
//   Inputs: synchronised, debounced, edge-detected; edges collected into
//   sticky, maskable event bits with an OR-ed interrupt.
//   LEDs: per-channel direct / PWM / blink / input-loopback drive, registered.
//
// Ports
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   raw_i        asynchronous board inputs            [N_IN]
//   in_o         debounced level                      [N_IN]
//   rise_o       one-cycle pulse with new in_o = 1    [N_IN]
//   fall_o       one-cycle pulse with new in_o = 0    [N_IN]
//   evt_o        sticky edge status                   [N_IN]
//   irq_mask_i   1 = channel edges set evt_o          [N_IN]
//   irq_clr_i    clears all evt_o (a same-cycle set wins)
//   irq_o        OR of evt_o
//   led_value_i  SoC LED value                        [N_LED]
//   led_mode_i   per-LED mode, channel i at [2i+1:2i] [2*N_LED]
//   led_duty_i   per-LED PWM duty, slice i            [PWM_WIDTH*N_LED]
//   led_o        registered LED drive                 [N_LED]
module board_io_conditioner #(
  parameter int unsigned N_IN            = 7,
  parameter int unsigned N_LED           = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned PWM_WIDTH       = 8,
  parameter int unsigned BLINK_DIV       = 50000000,
  parameter bit          RESET_LEVEL     = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N_IN-1:0]              raw_i,
  output logic [N_IN-1:0]              in_o,
  output logic [N_IN-1:0]              rise_o,
  output logic [N_IN-1:0]              fall_o,
  output logic [N_IN-1:0]              evt_o,
  input  logic [N_IN-1:0]              irq_mask_i,
  input  logic                         irq_clr_i,
  output logic                         irq_o,
  input  logic [N_LED-1:0]             led_value_i,
  input  logic [2*N_LED-1:0]           led_mode_i,
  input  logic [PWM_WIDTH*N_LED-1:0]   led_duty_i,
  output logic [N_LED-1:0]             led_o
);

  localparam int unsigned CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned PSW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PSW-1:0] PS_LAST = PSW'(BLINK_DIV - 1);

  // ---------------- synchroniser ----------------
  logic [N_IN-1:0] r_sync [SYNC_STAGES];
  logic [N_IN-1:0] w_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) r_sync[k] <= {N_IN{RESET_LEVEL}};
    end else begin
      r_sync[0] <= raw_i;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // ---------------- debounce and edge pulses ----------------
  logic [CW-1:0]   r_cnt [N_IN];
  logic [N_IN-1:0] r_in;
  logic [N_IN-1:0] r_rise;
  logic [N_IN-1:0] r_fall;
  logic [N_IN-1:0] w_accept;

  // A channel accepts its synchronised level on the edge where it has
  // differed from in_o for DEBOUNCE_CYCLES consecutive samples.
  always_comb begin
    w_accept = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      w_accept[i] = (w_s[i] != r_in[i]) && (r_cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_in   <= {N_IN{RESET_LEVEL}};
      r_rise <= '0;
      r_fall <= '0;
      for (int unsigned i = 0; i < N_IN; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        if ((w_s[i] == r_in[i]) || w_accept[i]) r_cnt[i] <= '0;
        else                                    r_cnt[i] <= r_cnt[i] + CW'(1);
      end
      r_in   <= r_in ^ w_accept;
      // Pulses are registered alongside the level so they coincide with it.
      r_rise <= w_accept &  w_s;
      r_fall <= w_accept & ~w_s;
    end
  end

  assign in_o   = r_in;
  assign rise_o = r_rise;
  assign fall_o = r_fall;

  // ---------------- sticky events ----------------
  logic [N_IN-1:0] r_evt;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_evt <= '0;
    else       r_evt <= (r_evt & ~{N_IN{irq_clr_i}}) | ((r_rise | r_fall) & irq_mask_i);
  end

  assign evt_o = r_evt;
  assign irq_o = |r_evt;

  // ---------------- shared PWM counter and blink prescaler ----------------
  logic [PWM_WIDTH-1:0] r_pc;
  logic [PSW-1:0]       r_presc;
  logic                 r_phase;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc    <= '0;
      r_presc <= '0;
      r_phase <= 1'b0;
    end else begin
      r_pc <= r_pc + PWM_WIDTH'(1);
      if (r_presc == PS_LAST) begin
        r_presc <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_presc <= r_presc + PSW'(1);
      end
    end
  end

  // ---------------- LED drive ----------------
  logic [N_LED-1:0] w_loop;
  logic [N_LED-1:0] w_led_next;
  logic [N_LED-1:0] r_led;

  // LEDs beyond the input count have nothing to loop back and read 0.
  for (genvar g = 0; g < N_LED; g++) begin : g_loop
    if (g < N_IN) begin : g_has_in
      assign w_loop[g] = r_in[g];
    end else begin : g_no_in
      assign w_loop[g] = 1'b0;
    end
  end

  always_comb begin
    w_led_next = '0;
    for (int unsigned i = 0; i < N_LED; i++) begin
      case (led_mode_i[2*i +: 2])
        2'b00:   w_led_next[i] = led_value_i[i];
        2'b01:   w_led_next[i] = led_value_i[i] & (r_pc < led_duty_i[i*PWM_WIDTH +: PWM_WIDTH]);
        2'b10:   w_led_next[i] = led_value_i[i] & r_phase;
        default: w_led_next[i] = w_loop[i];
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_led <= '0;
    else       r_led <= w_led_next;
  end

  assign led_o = r_led;

endmodule

// File: tb/tb_board_io_conditioner.sv
module tb_board_io_conditioner;

  localparam int N_IN  = 3;
  localparam int N_LED = 4;
  localparam int PW    = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_IN-1:0]        raw, in_o, rise, fall, evt, mask;
  logic                   clr, irq;
  logic [N_LED-1:0]       lval, led;
  logic [2*N_LED-1:0]     lmode;
  logic [PW*N_LED-1:0]    lduty;

  typedef struct { string tag; logic [31:0] exp; } sb_t;
  sb_t sb[$];
  int  n_vec = 0;
  int  n_err = 0;

  logic        v;
  int          ones, trans, viol;
  logic [39:0] b;
  int          duties [3] = '{0, 5, 15};

  always #5 clk = ~clk;

  board_io_conditioner #(
    .N_IN(N_IN), .N_LED(N_LED), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .PWM_WIDTH(PW), .BLINK_DIV(8), .RESET_LEVEL(1'b0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .raw_i(raw), .in_o(in_o), .rise_o(rise),
    .fall_o(fall), .evt_o(evt), .irq_mask_i(mask), .irq_clr_i(clr),
    .irq_o(irq), .led_value_i(lval), .led_mode_i(lmode),
    .led_duty_i(lduty), .led_o(led)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [31:0] e);
    sb.push_back('{tag, e});
  endtask

  task automatic compare(input logic [31:0] obs);
    sb_t it;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      it = sb.pop_front();
      assert (obs === it.exp) else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic expect_status(input string tag, input logic [2:0] e_in, input logic [2:0] e_rise,
                               input logic [2:0] e_fall, input logic [2:0] e_evt, input logic e_irq);
    expect_v({tag, "_in"},   32'(e_in));
    expect_v({tag, "_rise"}, 32'(e_rise));
    expect_v({tag, "_fall"}, 32'(e_fall));
    expect_v({tag, "_evt"},  32'(e_evt));
    expect_v({tag, "_irq"},  32'(e_irq));
  endtask

  task automatic compare_status();
    compare(32'(in_o));
    compare(32'(rise));
    compare(32'(fall));
    compare(32'(evt));
    compare(32'(irq));
  endtask

  initial begin
    // ---- reset state ----
    rst = 1'b1; raw = '0; mask = '1; clr = 1'b0; lval = '1; lmode = '0; lduty = '0;
    repeat (3) tick();
    expect_status("reset", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
    expect_v("reset_led", 32'h0);
    compare_status();
    compare(32'(led));

    rst = 1'b0; mask = 3'b010; lval = '0;
    repeat (2) tick();

    // ---- clean step on ch0: sampled at first tick, level 5 edges later ----
    raw[0] = 1'b1;
    for (int t = 1; t <= 7; t++) begin
      if (t < 6)       expect_status("step_wait",  3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
      else if (t == 6) expect_status("step_edge",  3'b001, 3'b001, 3'b000, 3'b000, 1'b0);
      else             expect_status("step_after", 3'b001, 3'b000, 3'b000, 3'b000, 1'b0);
      tick();
      compare_status();
    end

    // ---- 3-cycle glitch on ch1 is rejected ----
    raw[1] = 1'b1;
    repeat (3) tick();
    raw[1] = 1'b0;
    for (int t = 0; t < 8; t++) begin
      expect_status("glitch", 3'b001, 3'b000, 3'b000, 3'b000, 1'b0);
      tick();
      compare_status();
    end

    // ---- 4-cycle pulse on ch1 (masked in): rise, event, clear, fall, set-wins ----
    raw[1] = 1'b1;
    repeat (4) tick();
    raw[1] = 1'b0;
    expect_status("pulse_pre",  3'b001, 3'b000, 3'b000, 3'b000, 1'b0); tick(); compare_status();
    expect_status("pulse_rise", 3'b011, 3'b010, 3'b000, 3'b000, 1'b0); tick(); compare_status();
    expect_status("pulse_evt",  3'b011, 3'b000, 3'b000, 3'b010, 1'b1); tick(); compare_status();
    clr = 1'b1;
    expect_status("clr",        3'b011, 3'b000, 3'b000, 3'b000, 1'b0); tick(); compare_status();
    clr = 1'b0;
    expect_status("fall_wait",  3'b011, 3'b000, 3'b000, 3'b000, 1'b0); tick(); compare_status();
    expect_status("fall_edge",  3'b001, 3'b000, 3'b010, 3'b000, 1'b0); tick(); compare_status();
    clr = 1'b1;
    expect_status("set_wins",   3'b001, 3'b000, 3'b000, 3'b010, 1'b1); tick(); compare_status();
    expect_status("clr2",       3'b001, 3'b000, 3'b000, 3'b000, 1'b0); tick(); compare_status();
    clr = 1'b0;

    // ---- masked-off ch0 fall produces no event ----
    raw[0] = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      if (t < 6)       expect_status("m0_wait", 3'b001, 3'b000, 3'b000, 3'b000, 1'b0);
      else if (t == 6) expect_status("m0_fall", 3'b000, 3'b000, 3'b001, 3'b000, 1'b0);
      else             expect_status("m0_evt",  3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
      tick();
      compare_status();
    end

    // ---- PWM on LED0, direct on LED1 ----
    lmode = 8'b00_00_00_01;
    lval  = 4'b0001;
    foreach (duties[d]) begin
      lduty[3:0] = 4'(duties[d]);
      tick();
      ones = 0;
      for (int t = 0; t < 16; t++) begin
        v = 1'($urandom);
        expect_v("direct_led1", 32'(v));
        lval[1] = v;
        tick();
        compare(32'(led[1]));
        ones += int'(led[0]);
      end
      expect_v($sformatf("pwm_duty%0d", duties[d]), 32'(duties[d]));
      compare(32'(ones));
    end
    lval[0] = 1'b0;
    tick();
    ones = 0;
    for (int t = 0; t < 16; t++) begin
      tick();
      ones += int'(led[0]);
    end
    expect_v("pwm_value0", 32'h0);
    compare(32'(ones));

    // ---- blink on LED2 ----
    lmode = 8'b00_10_00_00;
    lval  = 4'b0100;
    tick();
    for (int t = 0; t < 40; t++) begin
      tick();
      b[t] = led[2];
    end
    ones = 0; trans = 0; viol = 0;
    for (int t = 0; t < 16; t++) ones += int'(b[t]);
    for (int t = 0; t < 32; t++) begin
      if (b[t] != b[t+1]) trans++;
      if (b[t] == b[t+8]) viol++;
    end
    expect_v("blink_ones16", 32'd8);
    expect_v("blink_trans32", 32'd4);
    expect_v("blink_halfperiod", 32'd0);
    compare(32'(ones));
    compare(32'(trans));
    compare(32'(viol));
    lval[2] = 1'b0;
    tick();
    ones = 0;
    for (int t = 0; t < 16; t++) begin
      tick();
      ones += int'(led[2]);
    end
    expect_v("blink_value0", 32'h0);
    compare(32'(ones));

    // ---- loopback: LED0 follows in_o[0]; LED3 has no input ----
    mask  = 3'b111;
    lmode = 8'b11_10_00_11;
    lval  = 4'b1111;
    raw[0] = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      expect_v("loop_led0", (t >= 7) ? 32'h1 : 32'h0);
      expect_v("loop_led3", 32'h0);
      tick();
      compare(32'(led[0]));
      compare(32'(led[3]));
    end

    // ---- reset two cycles into a ch2 debounce count ----
    raw[2] = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    for (int t = 0; t < 2; t++) begin
      expect_status("midrst", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
      expect_v("midrst_led", 32'h0);
      tick();
      compare_status();
      compare(32'(led));
    end
    rst = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      if (t < 6)       expect_status("post_wait", 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
      else if (t == 6) expect_status("post_edge", 3'b101, 3'b101, 3'b000, 3'b000, 1'b0);
      else             expect_status("post_hold", 3'b101, 3'b000, 3'b000, 3'b101, 1'b1);
      tick();
      compare_status();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
